// File: rtl/ram_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_access_arbiter
//  Purpose  : Two-port round-robin arbiter and access sequencer for the
//             synchronous RAM on the shared sysbus. Port 0 is the processor
//             sequencer and port 1 is the loader/DMA. Each accepted word
//             request is turned into the ordered strobe sequence
//             load_MAR -> [load_MDR] -> CS -> [MDR_bus], followed by a
//             one-cycle ack. Out-of-range addresses get a one-cycle err and
//             never touch the RAM.
//  Ports    : clock, n_reset              - clock, async active-low reset
//             req*/we*/addr*/wdata*       - per-port request, held to ack/err
//             gnt*/ack*/err*              - per-port ownership and status
//             rdata                       - read data, valid with ack
//             busy                        - sequencer not idle
//             load_MAR/load_MDR/CS/R_NW/MDR_bus - RAM strobes
//             sysbus                      - shared bus, driven in ADDR/WDATA
//  Revision : 1.0 - initial release
// ============================================================================
module ram_access_arbiter #(
    parameter int WORD_W  = 8,
    parameter int OP_W    = 3,
    parameter int ADDR_LO = 22,
    parameter int ADDR_HI = 29
) (
    input  logic                     clock,
    input  logic                     n_reset,
    input  logic                     req0,
    input  logic                     req1,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [WORD_W-OP_W-1:0]   addr0,
    input  logic [WORD_W-OP_W-1:0]   addr1,
    input  logic [WORD_W-1:0]        wdata0,
    input  logic [WORD_W-1:0]        wdata1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic                     ack0,
    output logic                     ack1,
    output logic                     err0,
    output logic                     err1,
    output logic [WORD_W-1:0]        rdata,
    output logic                     busy,
    output logic                     load_MAR,
    output logic                     load_MDR,
    output logic                     CS,
    output logic                     R_NW,
    output logic                     MDR_bus,
    inout  wire  [WORD_W-1:0]        sysbus
);

    localparam int AW = WORD_W - OP_W;
    localparam logic [AW-1:0] c_addr_lo = AW'(ADDR_LO);
    localparam logic [AW-1:0] c_addr_hi = AW'(ADDR_HI);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_WDATA  = 3'd2,
        S_ACCESS = 3'd3,
        S_READ   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_next;

    // Operands captured when a request is accepted; the access in flight
    // only ever looks at these, never at the live request inputs.
    logic                r_port;
    logic                r_we;
    logic [AW-1:0]       r_addr;
    logic [WORD_W-1:0]   r_wdata;
    logic [WORD_W-1:0]   r_rdata;
    // Port that wins when both request in the same IDLE cycle.
    logic                r_prio;

    logic                w_any_req;
    logic                w_sel;
    logic [AW-1:0]       w_sel_addr;
    logic                w_in_range;
    logic                w_owner;
    logic                w_bus_en;
    logic [WORD_W-1:0]   w_bus_val;

    // Request selection: round-robin only matters on a tie; a lone
    // requester is always the one selected.
    always_comb begin
        w_any_req  = req0 | req1;
        w_sel      = (req0 && req1) ? r_prio : req1;
        w_sel_addr = w_sel ? addr1 : addr0;
        w_in_range = (w_sel_addr >= c_addr_lo) && (w_sel_addr <= c_addr_hi);
    end

    // State register
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and Moore-decoded outputs
    always_comb begin
        w_next    = r_state;
        load_MAR  = 1'b0;
        load_MDR  = 1'b0;
        CS        = 1'b0;
        R_NW      = 1'b0;
        MDR_bus   = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        err0      = 1'b0;
        err1      = 1'b0;
        w_bus_en  = 1'b0;
        w_bus_val = '0;
        busy      = (r_state != S_IDLE);
        // The granted port owns the RAM from ADDR through DONE; ERR is
        // deliberately excluded because no RAM access takes place.
        w_owner   = (r_state == S_ADDR)  || (r_state == S_WDATA) ||
                    (r_state == S_ACCESS) || (r_state == S_READ) ||
                    (r_state == S_DONE);
        gnt0      = w_owner & ~r_port;
        gnt1      = w_owner &  r_port;

        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next = w_in_range ? S_ADDR : S_ERR;
                end
            end
            S_ADDR: begin
                w_bus_en  = 1'b1;
                w_bus_val = {{OP_W{1'b0}}, r_addr};
                load_MAR  = 1'b1;
                w_next    = r_we ? S_WDATA : S_ACCESS;
            end
            S_WDATA: begin
                w_bus_en  = 1'b1;
                w_bus_val = r_wdata;
                load_MDR  = 1'b1;
                w_next    = S_ACCESS;
            end
            S_ACCESS: begin
                CS     = 1'b1;
                R_NW   = ~r_we;
                w_next = r_we ? S_DONE : S_READ;
            end
            S_READ: begin
                MDR_bus = 1'b1;
                w_next  = S_DONE;
            end
            S_DONE: begin
                ack0   = ~r_port;
                ack1   =  r_port;
                w_next = S_IDLE;
            end
            S_ERR: begin
                err0   = ~r_port;
                err1   =  r_port;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, read-data capture and priority rotation
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_port  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_prio  <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && w_any_req) begin
                r_port  <= w_sel;
                r_we    <= w_sel ? we1 : we0;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel ? wdata1 : wdata0;
            end
            // The RAM drives its MDR onto sysbus during READ.
            if (r_state == S_READ) begin
                r_rdata <= sysbus;
            end
            // Hand priority to the port that was not just served. An access
            // aborted by reset never reaches here, so it does not rotate.
            if ((r_state == S_DONE) || (r_state == S_ERR)) begin
                r_prio <= ~r_port;
            end
        end
    end

    assign rdata  = r_rdata;
    assign sysbus = w_bus_en ? w_bus_val : {WORD_W{1'bz}};

endmodule
`default_nettype wire
